// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage (data wins ties).
// Optional stall performance counters are enabled with `define MEM_ARB_PERF_EN.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate data over fetch
// IF_ACC | fetch access driving memory for WAIT_STATES+1 cycles
// D_ACC  | data access driving memory for WAIT_STATES+1 cycles
// DONE   | ack cycle; hand over to the other requester if it is waiting
module mem_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_stall,
    output logic [31:0]           perf_d_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2,
        DONE   = 2'd3
    } arbState_t;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    arbState_t  state;
    logic [3:0] waitCnt;
    logic       servingData;
    logic       dReq;
    logic       grantData;
    logic       grantFetch;

    assign dReq      = d_read | d_write;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dReq & ~d_ack;

    // From DONE only the requester that was not just served may be granted.
    always_comb begin
        grantData  = 1'b0;
        grantFetch = 1'b0;
        case (state)
            IDLE: begin
                grantData  = dReq;
                grantFetch = ~dReq & if_req;
            end
            DONE: begin
                grantData  = ~servingData & dReq;
                grantFetch = servingData & if_req;
            end
            default: begin
                grantData  = 1'b0;
                grantFetch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            waitCnt     <= 4'd0;
            servingData <= 1'b0;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (state == IF_ACC || state == D_ACC) begin
                if (waitCnt == 4'd0) begin
                    // mem_we still reflects the access type during the last access cycle
                    if (state == IF_ACC) begin
                        if_rdata <= mem_rdata;
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                    if_ack <= (state == IF_ACC);
                    d_ack  <= (state == D_ACC);
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= DONE;
                end else begin
                    waitCnt <= waitCnt - 4'd1;
                end
            end else if (grantData || grantFetch) begin
                state       <= grantData ? D_ACC : IF_ACC;
                servingData <= grantData;
                waitCnt     <= WaitLoad;
                mem_addr    <= grantData ? d_addr : if_addr;
                mem_re      <= grantFetch | (grantData & ~d_write);
                mem_we      <= grantData & d_write;
                if (grantData) begin
                    mem_wdata <= d_wdata;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_stall <= 32'd0;
            perf_d_stall  <= 32'd0;
        end else begin
            perf_if_stall <= perf_if_stall + 32'(stall_if);
            perf_d_stall  <= perf_d_stall + 32'(stall_mem);
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single-ported unified memory shared by the pipeline's instruction-fetch stage and MEM stage (lw/sw). It grants one access at a time and holds the memory address, data and strobes for a configurable number of wait states. It returns registered read data with a one-cycle ack pulse. It generates stall_if / stall_mem, which feed the pipeline registers and the Control unit's stall input.

Parameters:
DATA_WIDTH, 32, memory data width
ADDR_WIDTH, 32, memory byte-address width
WAIT_STATES, 2, extra memory cycles per access; legal range 0..15; 4-bit down-counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held high until if_ack
if_addr  input  ADDR_WIDTH  fetch address (PC)
if_rdata  output  DATA_WIDTH  fetched instruction, registered
if_ack  output  1  one-cycle pulse; if_rdata valid
d_read  input  1  MemRead from MEM stage
d_write  input  1  MemWrite from MEM stage
d_addr  input  ADDR_WIDTH  data address (ALU result)
d_wdata  input  DATA_WIDTH  store data
d_rdata  output  DATA_WIDTH  load data, registered
d_ack  output  1  one-cycle pulse; data access complete
stall_if  output  1  if_req & ~if_ack
stall_mem  output  1  (d_read | d_write) & ~d_ack
mem_addr  output  ADDR_WIDTH  address to memory
mem_wdata  output  DATA_WIDTH  write data to memory
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_rdata  input  DATA_WIDTH  memory read data, valid in last access cycle

Behaviour:
- States: IDLE, IF_ACC, D_ACC, DONE. State, latched address/wdata/type, counter, rdata and ack regs are all registered.
- Reset (sync): state=IDLE; if_ack=d_ack=0; if_rdata=d_rdata=0; mem_re=mem_we=0; mem_addr=mem_wdata=0; counter=0.
- Reset mid-access aborts the access: no ack is issued, strobes drop at that edge, and the aborted request must be re-arbitrated.
- Arbitration in IDLE: data request (d_read|d_write) has priority over if_req, since the older instruction goes first.
- On grant, latch addr/wdata/type and load counter=WAIT_STATES. Input changes during an access are ignored.
- d_read and d_write both high is treated as a write.
- IF_ACC / D_ACC: mem_addr/mem_wdata come from the latches.
  - mem_re is high for reads and IF_ACC; mem_we is high for D_ACC writes.
  - Duration is exactly WAIT_STATES+1 cycles; the counter decrements each cycle.
  - At the edge where counter==0: capture mem_rdata into if_rdata (IF) or d_rdata (data reads only; writes leave d_rdata unchanged), then go to DONE.
- DONE: the matching ack is high for exactly this cycle; strobes are low.
  - If the other requester is pending, grant it directly (no IDLE bubble). Otherwise go to IDLE.
  - The just-acked requester is not re-granted from DONE.
- Latency: request seen in IDLE at cycle 0 gives access cycles 1..W+1 and ack at cycle W+2.
- Back-to-back: the second requester's access starts at cycle W+3.
- A request high in IDLE is always a new request. The requester may present its next request in the cycle after its ack.
- Stalls are combinational from requests and registered acks, so stall is low in the ack cycle.

Optional Feature:
MEM_ARB_PERF_EN. When defined, add outputs perf_if_stall [31:0] and perf_d_stall [31:0].
- Each counts cycles with stall_if / stall_mem high; reset to 0; wraps at 2^32.
When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. W=2, if_req at cyc0, if_addr=0x00400000, mem_rdata=0x20080005 -> mem_re high cyc1-3, mem_addr=0x00400000, if_ack cyc4 only, if_rdata=0x20080005, stall_if high cyc0-3.
2. W=2, if_req and d_read (d_addr=0x10010000) both at cyc0 -> D_ACC cyc1-3, d_ack cyc4; IF_ACC cyc5-7, if_ack cyc8; stall_if high cyc0-7.
3. W=0, d_write, d_addr=0x10010004, d_wdata=0xDEADBEEF -> mem_we high cyc1 only, mem_wdata=0xDEADBEEF, d_ack cyc2, d_rdata unchanged, mem_re never high.
4. W=2, if_req cyc0, reset high cyc2 -> cyc3 state IDLE, mem_re=0, no if_ack. if_req still high after reset -> new access; if_ack 4 cycles after the IDLE cycle.
5. W=3, if_addr changes 0x00400000 -> 0x00400004 at cyc2 -> mem_addr stays 0x00400000 for cyc1-4; if_ack cyc5.
6. MEM_ARB_PERF_EN defined, scenario 2 -> perf_if_stall=8, perf_d_stall=4 at cyc9.
